// File: rtl/stream_selector_if.sv
// Handshake bundle for stream_selector: N producer channels in, one consumer channel out.
// master is the producer/consumer side; slave is the selector itself.
interface stream_selector_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4
);
  localparam int unsigned SEL_W = $clog2(N);

  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/stream_selector.sv
// Registered N:1 stream selector with direct (sel) or round-robin source choice
// and a single-slot output register that supports same-cycle pop and push.
module stream_selector #(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned N     = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input logic              clk,
  input logic              reset,
  stream_selector_if.slave bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;
  logic [SEL_W-1:0] rr_q,        rr_d;

  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             can_accept;
  logic             xfer;

  always_comb begin : grant_logic
    int unsigned j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!bus.mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Scan offsets high to low so the last hit is the one closest to rr_q.
      for (int unsigned k = N; k > 0; k--) begin
        j = 32'(rr_q) + k - 1;
        if (j >= N) j = j - N;
        if (bus.in_valid[j]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(j);
        end
      end
    end
  end

  always_comb begin : data_mux
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign can_accept = !out_valid_q || bus.out_ready;
  assign xfer       = grant_vld && can_accept && !reset;

  always_comb begin : ready_logic
    bus.in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.in_ready[i] = xfer && (grant_idx == SEL_W'(i));
    end
  end

  always_comb begin : next_state
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_d        = rr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_src_d   = grant_idx;
      rr_d        = (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end else if (bus.out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_q        <= rr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_stream_selector.sv
// Bench for stream_selector: directed scenarios plus random traffic against a
// transaction-level reference model (N=4), and a few directed checks on an N=3 instance.
module tb_stream_selector;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stream_selector_if #(.WIDTH(4), .N(4)) ifa ();
  stream_selector_if #(.WIDTH(4), .N(3)) ifb ();

  stream_selector #(.WIDTH(4), .N(4)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  stream_selector #(.WIDTH(4), .N(3)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  // Reference model state (N=4 instance)
  bit       m_valid;
  bit [3:0] m_data;
  int       m_src;
  int       m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns granted channel, or -1 when nothing may be granted.
  function automatic int ref_grant(input bit mode, input int sel, input logic [7:0] valid,
                                   input int n, input int rr);
    if (!mode) return (sel < n && valid[sel] === 1'b1) ? sel : -1;
    for (int k = 0; k < n; k++) begin
      int c;
      c = (rr + k) % n;
      if (valid[c] === 1'b1) return c;
    end
    return -1;
  endfunction

  // One clock of the N=4 instance: check ready before the edge, outputs after it.
  task automatic cyc_a();
    int       g;
    bit       can;
    bit [3:0] exp_ready;
    bit [15:0] d;
    #1;
    can = !m_valid || ifa.out_ready;
    g   = ref_grant(ifa.mode, int'(ifa.sel), {4'b0, ifa.in_valid}, 4, m_rr);
    exp_ready = (g >= 0 && can && !rst_a) ? 4'(1 << g) : 4'b0;
    chk("in_ready", {28'b0, ifa.in_ready}, {28'b0, exp_ready});
    d = ifa.in_data;
    @(posedge clk);
    if (rst_a) begin
      m_valid = 0; m_data = 0; m_src = 0; m_rr = 0;
    end else if (exp_ready != 0) begin
      m_data  = d[g*4 +: 4];
      m_src   = g;
      m_valid = 1;
      m_rr    = (g + 1) % 4;
    end else if (ifa.out_ready && m_valid) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", {31'b0, ifa.out_valid}, {31'b0, m_valid});
    chk("out_data", {28'b0, ifa.out_data}, {28'b0, m_data});
    chk("out_src", {30'b0, ifa.out_src}, 32'(m_src));
  endtask

  initial begin
    logic [3:0] held;

    ifa.mode = 0; ifa.sel = 0; ifa.in_data = 16'h4321; ifa.in_valid = 4'b1111; ifa.out_ready = 1;
    ifb.mode = 0; ifb.sel = 0; ifb.in_data = '0; ifb.in_valid = '0; ifb.out_ready = 1;
    rst_a = 1; rst_b = 1;

    // Reset with every channel valid: nothing accepted
    cyc_a(); cyc_a();
    chk("rst_out_valid", {31'b0, ifa.out_valid}, 32'd0);
    chk("rst_out_data", {28'b0, ifa.out_data}, 32'd0);
    rst_a = 0; ifa.mode = 1;
    cyc_a();
    chk("first_after_rst", {31'b0, ifa.out_valid}, 32'd1);

    // Direct mode
    ifa.mode = 0; ifa.sel = 2; ifa.in_data = 16'h0A00; ifa.in_valid = 4'b0100;
    cyc_a();
    chk("dir_data", {28'b0, ifa.out_data}, 32'hA);
    chk("dir_src", {30'b0, ifa.out_src}, 32'd2);
    ifa.sel = 1; ifa.in_valid = 4'b1101;
    cyc_a();
    chk("dir_nogrant", {31'b0, ifa.out_valid}, 32'd0);

    // Round-robin full throughput from a fresh pointer
    rst_a = 1; cyc_a(); cyc_a(); rst_a = 0;
    ifa.mode = 1; ifa.in_valid = 4'b1111; ifa.in_data = 16'h8765; ifa.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cyc_a();
      chk("rr_src", {30'b0, ifa.out_src}, 32'(i % 4));
      chk("rr_data", {28'b0, ifa.out_data}, 32'(i % 4 + 5));
    end

    // Backpressure then same-cycle pop+push
    ifa.out_ready = 0;
    held = ifa.out_data;
    for (int i = 0; i < 3; i++) begin
      cyc_a();
      chk("bp_stable", {28'b0, ifa.out_data}, {28'b0, held});
    end
    ifa.out_ready = 1; ifa.in_valid = 4'b1000;
    cyc_a();
    chk("popush_valid", {31'b0, ifa.out_valid}, 32'd1);
    chk("popush_src", {30'b0, ifa.out_src}, 32'd3);

    // Move pointer to 3, then skip/wrap, then switch to direct sel=3
    ifa.mode = 0; ifa.sel = 2; ifa.in_valid = 4'b0100;
    cyc_a();
    ifa.mode = 1; ifa.in_valid = 4'b0011;
    cyc_a(); chk("wrap0", {30'b0, ifa.out_src}, 32'd0);
    cyc_a(); chk("wrap1", {30'b0, ifa.out_src}, 32'd1);
    cyc_a(); chk("wrap2", {30'b0, ifa.out_src}, 32'd0);
    ifa.mode = 0; ifa.sel = 3; ifa.in_valid = 4'b1011;
    cyc_a(); chk("dir_switch", {30'b0, ifa.out_src}, 32'd3);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_a         = ($urandom_range(0, 39) == 0);
      ifa.mode      = 1'($urandom);
      ifa.sel       = 2'($urandom);
      ifa.in_valid  = 4'($urandom);
      ifa.in_data   = 16'($urandom);
      ifa.out_ready = ($urandom_range(0, 3) != 0);
      cyc_a();
    end
    rst_a = 0;

    // N=3: out-of-range sel never grants
    ifb.mode = 0; ifb.sel = 3; ifb.in_valid = 3'b111; ifb.in_data = 12'h5C3; ifb.out_ready = 1;
    @(posedge clk); #1;
    rst_b = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("n3_sel3_ready", {29'b0, ifb.in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("n3_sel3_valid", {31'b0, ifb.out_valid}, 32'd0);
    end
    ifb.sel = 1;
    #1;
    chk("n3_sel1_ready", {29'b0, ifb.in_ready}, 32'b010);
    @(posedge clk); #1;
    chk("n3_sel1_valid", {31'b0, ifb.out_valid}, 32'd1);
    chk("n3_sel1_data", {28'b0, ifb.out_data}, 32'hC);
    chk("n3_sel1_src", {30'b0, ifb.out_src}, 32'd1);
    // Reset while holding a word drops it
    ifb.out_ready = 0; rst_b = 1;
    #1;
    chk("n3_rst_ready", {29'b0, ifb.in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("n3_rst_valid", {31'b0, ifb.out_valid}, 32'd0);
    chk("n3_rst_data", {28'b0, ifb.out_data}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
